// File: rtl/simple_fifo_pkg.sv
// Shared defaults and pointer helper for the simple_fifo buffer.
// Pointers wrap explicitly, so DEPTH does not need to be a power of two.
package simple_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 32;

  // Next ring position: 0..depth-1, wrapping from depth-1 back to 0.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/simple_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port.
// The asynchronous read is what gives the parent FIFO its zero-latency head word.
module simple_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/simple_fifo.sv
// Single-clock show-ahead FIFO: pointers, occupancy count and flags around simple_fifo_ram.
// Full/empty are decoded from the registered count so they never glitch within a cycle.
module simple_fifo
  import simple_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);

  // Full gates the write and empty gates the read, so overflow/underflow requests vanish.
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_en) begin
      wr_ptr_next = PTR_W'(ptr_inc(int'(wr_ptr_reg), DEPTH));
    end
    if (rd_en) begin
      rd_ptr_next = PTR_W'(ptr_inc(int'(rd_ptr_reg), DEPTH));
    end
    if (wr_en && !rd_en) begin
      count_next = count_reg + CNT_W'(1);
    end else if (rd_en && !wr_en) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Memory is deliberately not reset; a reset only discards the pointers and count.
  simple_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en & ~rst),
    .waddr (wr_ptr_reg),
    .wdata (data_in),
    .raddr (rd_ptr_reg),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_simple_fifo.sv
// Self-checking bench for simple_fifo: queue model with a per-cycle compare process
// plus directed sequences carrying hand-computed literal expectations.
module tb_simple_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr  = 1'b0;
  logic             rd  = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [WIDTH-1:0] model_q[$];
  bit               model_valid = 1'b0;

  simple_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .rd       (rd),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated by the FIFO's accept rules at each edge.
  always @(posedge clk) begin
    if (rst) begin
      model_q.delete();
      model_valid = 1'b1;
    end else if (model_valid) begin
      bit do_wr;
      bit do_rd;
      do_wr = wr && (model_q.size() < DEPTH);
      do_rd = rd && (model_q.size() > 0);
      if (do_rd) void'(model_q.pop_front());
      if (do_wr) model_q.push_back(data_in);
    end
  end

  // Compare process: flags every cycle, head word whenever the model holds data.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("empty_vs_model", 32'(empty), 32'(model_q.size() == 0));
      chk("full_vs_model", 32'(full), 32'(model_q.size() == DEPTH));
      if (model_q.size() > 0) begin
        chk("data_out_vs_model", 32'(data_out), 32'(model_q[0]));
      end
    end
  end

  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
    wr      = w;
    rd      = r;
    data_in = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic pop_check(input logic [WIDTH-1:0] exp);
    rd = 1'b1;
    wr = 1'b0;
    @(negedge clk);
    chk("pop_literal", 32'(data_out), 32'(exp));
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset, then a read on an empty FIFO
    do_reset();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    step(1'b0, 1'b1, '0);
    chk("underflow_empty", 32'(empty), 32'd1);
    $display("phase 1 reset done");

    // 2: linear fill and drain
    for (int i = 1; i <= 32; i++) step(1'b1, 1'b0, WIDTH'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_empty", 32'(empty), 32'd0);
    for (int i = 1; i <= 32; i++) pop_check(WIDTH'(i));
    chk("drain_empty", 32'(empty), 32'd1);
    $display("phase 2 fill/drain done");

    // 3: overflow write is dropped
    for (int i = 1; i <= 32; i++) step(1'b1, 1'b0, WIDTH'(i));
    step(1'b1, 1'b0, 8'hAA);
    chk("overflow_full", 32'(full), 32'd1);
    for (int i = 1; i <= 32; i++) pop_check(WIDTH'(i));
    chk("overflow_drain_empty", 32'(empty), 32'd1);
    $display("phase 3 overflow done");

    // 4: simultaneous wr+rd when full, then when empty
    for (int i = 1; i <= 32; i++) step(1'b1, 1'b0, WIDTH'(100 + i));
    step(1'b1, 1'b1, 8'hAA);
    chk("full_wrrd_full", 32'(full), 32'd0);
    chk("full_wrrd_head", 32'(data_out), 32'd102);
    for (int i = 2; i <= 32; i++) pop_check(WIDTH'(100 + i));
    chk("full_wrrd_31_words", 32'(empty), 32'd1);
    step(1'b1, 1'b1, 8'h5C);
    chk("empty_wrrd_empty", 32'(empty), 32'd0);
    chk("empty_wrrd_data", 32'(data_out), 32'h5C);
    step(1'b0, 1'b1, '0);
    chk("empty_wrrd_count1", 32'(empty), 32'd1);
    $display("phase 4 simultaneous done");

    // 5: pointer wrap; 20-15+25 = 30 words, two more reach DEPTH
    do_reset();
    for (int i = 1; i <= 20; i++) step(1'b1, 1'b0, WIDTH'(i));
    for (int i = 1; i <= 15; i++) pop_check(WIDTH'(i));
    for (int i = 21; i <= 45; i++) step(1'b1, 1'b0, WIDTH'(i));
    chk("wrap_30_not_full", 32'(full), 32'd0);
    step(1'b1, 1'b0, 8'd46);
    step(1'b1, 1'b0, 8'd47);
    chk("wrap_32_full", 32'(full), 32'd1);
    for (int i = 16; i <= 47; i++) pop_check(WIDTH'(i));
    chk("wrap_drain_empty", 32'(empty), 32'd1);
    $display("phase 5 wrap done");

    // 6: random traffic with periodic reset; bias varies per block to reach both flags
    for (int cyc = 0; cyc < 1000; cyc++) begin
      int wp;
      int rp;
      wp  = ((cyc / 100) % 2 == 0) ? 75 : 30;
      rp  = 100 - wp;
      rst = (cyc % 100 == 0);
      step(($urandom_range(99) < wp), ($urandom_range(99) < rp), WIDTH'($urandom));
      rst = 1'b0;
    end
    $display("phase 6 random done");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
